mc_control: RTL and testbench

//  Multicycle MIPS main control FSM, directly upstream of the ALU control decoder.

---
 rtl/mc_control.sv | 194 +++++++++++++++++++
 tb/tb_mc_control.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
`timescale 1ns/1ps
// mc_control
//   Main control FSM for a multicycle MIPS datapath. It decodes the IR opcode
//   and steps through fetch / decode / execute / memory / writeback, one step
//   per clock. It drives the datapath mux selects, the write enables and the
//   2-bit ALUOp consumed by the downstream ALU control decoder. Memory steps
//   wait on MemReady.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   Opcode[5:0]       IR[31:26], sampled in DECODE and MEMADR only
//   MemReady          memory finishes the current read/write this cycle
//   PCWrite           unconditional PC load
//   PCWriteCond       PC load qualified by ALU Zero
//   IorD              memory address select, 0=PC 1=ALUOut
//   MemRead/MemWrite  memory requests
//   IRWrite           instruction register load
//   MemtoReg          register write data select, 0=ALUOut 1=MDR
//   RegDst            write register select, 0=rt 1=rd
//   RegWrite          register file write enable
//   ALUSrcA           0=PC 1=regA
//   ALUSrcB[1:0]      00=regB 01=4 10=signext imm 11=signext imm<<2
//   ALUOp[1:0]        00=add 01=sub 10=funct-decoded
//   PCSource[1:0]     00=ALU result 01=ALUOut 10=jump target
//   Illegal           one-cycle pulse when DECODE sees an unknown opcode
//   State[3:0]        current state, debug visibility only
module mc_control #(
  parameter logic [5:0] OP_R    = 6'h00,
  parameter logic [5:0] OP_LW   = 6'h23,
  parameter logic [5:0] OP_SW   = 6'h2B,
  parameter logic [5:0] OP_BEQ  = 6'h04,
  parameter logic [5:0] OP_J    = 6'h02,
  parameter logic [5:0] OP_ADDI = 6'h08
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       Illegal,
  output logic [3:0] State
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_ADDIEX = 4'd10;
  localparam logic [3:0] S_ADDIWB = 4'd11;
  localparam logic [3:0] S_RST    = 4'd15;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       op_known;

  assign op_known = (Opcode == OP_R)   || (Opcode == OP_LW)  ||
                    (Opcode == OP_SW)  || (Opcode == OP_BEQ) ||
                    (Opcode == OP_J)   || (Opcode == OP_ADDI);

  // Next-state logic. Unknown opcodes in DECODE fall back to FETCH without
  // rewinding the PC; the unused codes 12-14 also recover through FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  state_d = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if ((Opcode == OP_LW) || (Opcode == OP_SW)) state_d = S_MEMADR;
        else if (Opcode == OP_R)                    state_d = S_EXEC;
        else if (Opcode == OP_BEQ)                  state_d = S_BRANCH;
        else if (Opcode == OP_J)                    state_d = S_JUMP;
        else if (Opcode == OP_ADDI)                 state_d = S_ADDIEX;
        else                                        state_d = S_FETCH;
      end
      S_MEMADR: begin
        if (Opcode == OP_SW)      state_d = S_MEMWR;
        else if (Opcode == OP_LW) state_d = S_MEMRD;
        else                      state_d = S_FETCH;
      end
      S_MEMRD:  state_d = MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = MemReady ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Asynchronous reset parks the FSM in RST, whose decode is all-zero, so a
  // reset mid-instruction drops every enable immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RST;
    else        state_q <= state_d;
  end

  // Output decode: Moore outputs from the state, except IRWrite/PCWrite in
  // FETCH, which follow MemReady so PC+4 and the IR load land on the same edge
  // that the fetch completes.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    Illegal     = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        Illegal = ~op_known;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign State = state_q;

endmodule

// File: tb/tb_mc_control.sv
`timescale 1ns/1ps
// tb_mc_control
//   Bench for the multicycle MIPS main control FSM. Instructions are described
//   as a list of steps (fetch, decode, then the opcode's own steps, with
//   memory stalls inserted); each driven cycle pushes the expected output
//   vector into a queue and an independent monitor pops and compares it on
//   the falling edge.
module tb_mc_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] Opcode = 6'h00;
  logic       MemReady = 1'b1;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, Illegal;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] State;

  always #5 clk = ~clk;

  mc_control dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .Illegal(Illegal), .State(State)
  );

  typedef enum int {
    phReset, phFetch, phDecode, phMemAdr, phMemRd, phMemWb, phMemWr,
    phExec, phAluWb, phBranch, phJump, phAddiEx, phAddiWb
  } phase_e;

  typedef logic [20:0] obs_t;

  obs_t       expQ[$];
  int         total = 0;
  int         bad = 0;
  int         cycleNum = 0;
  obs_t       observed;

  assign observed = {State, PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
                     IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB,
                     ALUOp, PCSource, Illegal};

  // Expected outputs of one step, straight from the per-step control table.
  function automatic obs_t expectFor(phase_e ph, logic mr, logic ill);
    logic [3:0] st;
    logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, illo;
    logic [1:0] srcb, aop, psrc;
    st = 4'd15; pcw = 0; pcwc = 0; iord = 0; mrd = 0; mwr = 0; irw = 0;
    m2r = 0; rdst = 0; rw = 0; srca = 0; srcb = 2'b00; aop = 2'b00;
    psrc = 2'b00; illo = 0;
    case (ph)
      phReset:  st = 4'd15;
      phFetch:  begin st = 4'd0; mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      phDecode: begin st = 4'd1; srcb = 2'b11; illo = ill; end
      phMemAdr: begin st = 4'd2; srca = 1; srcb = 2'b10; end
      phMemRd:  begin st = 4'd3; mrd = 1; iord = 1; end
      phMemWb:  begin st = 4'd4; rw = 1; m2r = 1; end
      phMemWr:  begin st = 4'd5; mwr = 1; iord = 1; end
      phExec:   begin st = 4'd6; srca = 1; aop = 2'b10; end
      phAluWb:  begin st = 4'd7; rw = 1; rdst = 1; end
      phBranch: begin st = 4'd8; srca = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
      phJump:   begin st = 4'd9; pcw = 1; psrc = 2'b10; end
      phAddiEx: begin st = 4'd10; srca = 1; srcb = 2'b10; end
      phAddiWb: begin st = 4'd11; rw = 1; end
      default:  st = 4'd15;
    endcase
    return {st, pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca,
            srcb, aop, psrc, illo};
  endfunction

  function automatic logic isLegal(logic [5:0] op);
    return (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) ||
           (op == 6'h04) || (op == 6'h02) || (op == 6'h08);
  endfunction

  task automatic checkOutput(input string name, input obs_t want);
    total++;
    if (observed !== want) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", name, cycleNum,
               observed, want);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge and queue what the
  // DUT must show for the rest of that cycle.
  task automatic applyStimulus(input phase_e ph, input logic rstV,
                               input logic mr, input logic [5:0] op,
                               input logic ill);
    @(posedge clk);
    #1;
    rst_n    = rstV;
    MemReady = mr;
    Opcode   = op;
    expQ.push_back(expectFor(ph, mr, ill));
  endtask

  // One full instruction: fetch (with stalls), decode, then the opcode's
  // steps. Memory steps get memStalls not-ready cycles before completing.
  task automatic runInstr(input logic [5:0] op, input int fetchStalls,
                          input int memStalls);
    repeat (fetchStalls) applyStimulus(phFetch, 1'b1, 1'b0, 6'($urandom), 1'b0);
    applyStimulus(phFetch, 1'b1, 1'b1, 6'($urandom), 1'b0);
    applyStimulus(phDecode, 1'b1, 1'($urandom), op, !isLegal(op));
    case (op)
      6'h23: begin
        applyStimulus(phMemAdr, 1'b1, 1'($urandom), op, 1'b0);
        repeat (memStalls) applyStimulus(phMemRd, 1'b1, 1'b0, op, 1'b0);
        applyStimulus(phMemRd, 1'b1, 1'b1, op, 1'b0);
        applyStimulus(phMemWb, 1'b1, 1'($urandom), op, 1'b0);
      end
      6'h2B: begin
        applyStimulus(phMemAdr, 1'b1, 1'($urandom), op, 1'b0);
        repeat (memStalls) applyStimulus(phMemWr, 1'b1, 1'b0, op, 1'b0);
        applyStimulus(phMemWr, 1'b1, 1'b1, op, 1'b0);
      end
      6'h00: begin
        applyStimulus(phExec, 1'b1, 1'($urandom), op, 1'b0);
        applyStimulus(phAluWb, 1'b1, 1'($urandom), op, 1'b0);
      end
      6'h08: begin
        applyStimulus(phAddiEx, 1'b1, 1'($urandom), op, 1'b0);
        applyStimulus(phAddiWb, 1'b1, 1'($urandom), op, 1'b0);
      end
      6'h04: applyStimulus(phBranch, 1'b1, 1'($urandom), op, 1'b0);
      6'h02: applyStimulus(phJump, 1'b1, 1'($urandom), op, 1'b0);
      default: ;
    endcase
  endtask

  function automatic logic [5:0] randomOpcode();
    logic [5:0] legal[6];
    logic [5:0] op;
    legal = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
    if ($urandom_range(0, 7) == 0) begin
      op = 6'($urandom);
      while (isLegal(op)) op = 6'($urandom);
    end else begin
      op = legal[$urandom_range(0, 5)];
    end
    return op;
  endfunction

  // Monitor: compares one queued expectation per cycle and checks the
  // mutual-exclusion rules on the enables every cycle.
  always @(negedge clk) begin
    cycleNum++;
    if (expQ.size() > 0) checkOutput("outputs", expQ.pop_front());
    total++;
    if (MemRead && MemWrite) begin
      bad++;
      $display("[TB] FAIL mem_rw_excl cycle=%0d got=11 expected=not both", cycleNum);
    end
    total++;
    if (RegWrite && PCWrite) begin
      bad++;
      $display("[TB] FAIL reg_pc_excl cycle=%0d got=11 expected=not both", cycleNum);
    end
  end

  initial begin
    // Reset held, then released one cycle before the FSM leaves RST.
    repeat (3) applyStimulus(phReset, 1'b0, 1'b1, 6'h00, 1'b0);
    applyStimulus(phReset, 1'b1, 1'b1, 6'h00, 1'b0);

    // Directed sequences: LW, SW with a 3-cycle write stall, R then BEQ,
    // an unknown opcode, then J and ADDI.
    runInstr(6'h23, 0, 0);
    runInstr(6'h2B, 0, 3);
    runInstr(6'h00, 0, 0);
    runInstr(6'h04, 0, 0);
    runInstr(6'h3F, 0, 0);
    runInstr(6'h02, 1, 0);
    runInstr(6'h08, 2, 0);

    // Reset while MEMRD is stalled: the FSM must drop to RST at once and
    // never reach the load writeback.
    applyStimulus(phFetch, 1'b1, 1'b1, 6'h11, 1'b0);
    applyStimulus(phDecode, 1'b1, 1'b1, 6'h23, 1'b0);
    applyStimulus(phMemAdr, 1'b1, 1'b1, 6'h23, 1'b0);
    applyStimulus(phMemRd, 1'b1, 1'b0, 6'h23, 1'b0);
    applyStimulus(phMemRd, 1'b1, 1'b0, 6'h23, 1'b0);
    applyStimulus(phReset, 1'b0, 1'b0, 6'h23, 1'b0);
    #1;
    checkOutput("async_reset", expectFor(phReset, 1'b0, 1'b0));
    applyStimulus(phReset, 1'b1, 1'b1, 6'h23, 1'b0);

    // Randomised instruction stream with random stalls.
    for (int i = 0; i < 150; i++) begin
      runInstr(randomOpcode(),
               ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0,
               ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    repeat (2) @(posedge clk);
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain got=%0d pending expected=0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
